// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, oversampling constants
// and the parity helper used by the TX framer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } tx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SMP_TOP    = 4'd15;
    localparam int         BYTE_W     = 8;

    // Even parity is the XOR of the byte; odd parity is its complement.
    function automatic logic parity_bit(input logic [BYTE_W-1:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// 16x oversampling sub-bit counter: counts clken ticks, strobes bit_end_o on
// the tick that completes a bit. Shared between the UART TX and RX paths.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clken_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance only on a tick (wraps 15 -> 0).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (clken_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = clken_i && !clr_i && (cnt_q == SMP_TOP);

endmodule

// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: accepts a NUM_BYTES word and sends it as
// back-to-back 8N1/8N2 bytes. Optional parity bit via `UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int NUM_BYTES  = 4,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clken_16bps,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [NUM_BYTES*BYTE_W-1:0] tx_data,
    output logic                        txd,
    output logic                        busy,
    output logic                        byte_done,
    output logic                        frame_done
);

    localparam int         WORD_W    = NUM_BYTES * BYTE_W;
    localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);
    localparam logic [7:0] STOP_LAST = 8'(STOP_BITS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_BITS - 1);

    if (NUM_BYTES < 1 || NUM_BYTES > 8) begin : g_bad_num_bytes
        $error("uart_tx_frame: NUM_BYTES must be 1..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (GAP_BITS < 0 || GAP_BITS > 255) begin : g_bad_gap_bits
        $error("uart_tx_frame: GAP_BITS must be 0..255");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    tx_state_t         state_q;
    logic [WORD_W-1:0] shift_q;
    logic [7:0]        cnt_q;
    logic [2:0]        byte_idx_q;
    logic              txd_q;
    logic              ready_q;
    logic              busy_q;
    logic              byte_done_q;
    logic              frame_done_q;
    logic              bit_end_s;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    // Sub-bit timer is held clear in IDLE so every frame starts phase-aligned to accept.
    uart_bit_timer u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clken_i   (clken_16bps),
        .clr_i     (state_q == IDLE),
        .bit_end_o (bit_end_s)
    );

    // Framing FSM; the line level and all status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= {WORD_W{1'b0}};
            cnt_q        <= 8'd0;
            byte_idx_q   <= 3'd0;
            txd_q        <= 1'b1;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            byte_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            byte_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_valid && ready_q) begin
                        state_q    <= START;
                        shift_q    <= tx_data;
                        cnt_q      <= 8'd0;
                        byte_idx_q <= 3'd0;
                        txd_q      <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        state_q <= DATA;
                        cnt_q   <= 8'd0;
                        txd_q   <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                        par_q   <= parity_bit(shift_q[BYTE_W-1:0], PARITY_ODD != 0);
`endif
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        // Shifting the whole word leaves the next byte in [7:0].
                        shift_q <= {1'b0, shift_q[WORD_W-1:1]};
                        if (cnt_q == 8'd7) begin
                            cnt_q <= 8'd0;
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            txd_q   <= par_q;
`else
                            state_q <= STOP;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                            txd_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end_s) begin
                        state_q <= STOP;
                        cnt_q   <= 8'd0;
                        txd_q   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end_s) begin
                        if (cnt_q == STOP_LAST) begin
                            cnt_q       <= 8'd0;
                            byte_done_q <= 1'b1;
                            if (byte_idx_q == LAST_BYTE) begin
                                state_q      <= IDLE;
                                ready_q      <= 1'b1;
                                busy_q       <= 1'b0;
                                frame_done_q <= 1'b1;
                            end else if (GAP_BITS == 0) begin
                                state_q    <= START;
                                byte_idx_q <= byte_idx_q + 3'd1;
                                txd_q      <= 1'b0;
                            end else begin
                                state_q    <= GAP;
                                byte_idx_q <= byte_idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (bit_end_s) begin
                        if (cnt_q == GAP_LAST) begin
                            state_q <= START;
                            cnt_q   <= 8'd0;
                            txd_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign txd        = txd_q;
    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign byte_done  = byte_done_q;
    assign frame_done = frame_done_q;

endmodule
